// File: rtl/program_loader.sv
// program_loader: bus-master sequencer that streams a program image into RAM
// while holding the CPU off the shared bus. Each accepted byte costs one MAR
// load cycle and one RAM write cycle.
module program_loader #(
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  inout  wire  [DATA_WIDTH-1:0] bus,
  output logic                  mai,
  output logic                  mi,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [DATA_WIDTH-1:0] LastAddr = DATA_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StWait, StAddr, StWrite, StFinish} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  aborted_q, aborted_d;
  logic                  bus_oe;
  logic [DATA_WIDTH-1:0] bus_val;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      hold_q     <= '0;
      checksum_q <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hold_q     <= hold_d;
      checksum_q <= checksum_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next-state and datapath update; abort overrides every non-idle transition.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    checksum_d = checksum_q;
    aborted_d  = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StWait;
          addr_d     = '0;
          checksum_d = '0;
          aborted_d  = 1'b0;
        end
      end
      StWait: begin
        if (in_valid) begin
          hold_d     = in_data;
          checksum_d = checksum_q + in_data;
          state_d    = StAddr;
        end
      end
      StAddr: state_d = StWrite;
      StWrite: begin
        // Stop on the last address so the counter never wraps inside a load.
        if (addr_q == LastAddr) begin
          state_d = StFinish;
        end else begin
          addr_d  = addr_q + DATA_WIDTH'(1);
          state_d = StWait;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // The in-flight byte is dropped; a write already on the bus still lands.
    if ((state_q != StIdle) && abort) begin
      state_d    = StIdle;
      aborted_d  = 1'b1;
      addr_d     = addr_q;
      hold_d     = hold_q;
      checksum_d = checksum_q;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    in_ready = 1'b0;
    mai      = 1'b0;
    mi       = 1'b0;
    done     = 1'b0;
    bus_oe   = 1'b0;
    bus_val  = hold_q;
    unique case (state_q)
      StWait:   in_ready = 1'b1;
      StAddr: begin
        mai     = 1'b1;
        bus_oe  = 1'b1;
        bus_val = addr_q;
      end
      StWrite: begin
        mi     = 1'b1;
        bus_oe = 1'b1;
      end
      StFinish: done = 1'b1;
      default:  ;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign cpu_hold = busy;
  assign aborted  = aborted_q;
  assign checksum = checksum_q;
  assign bus      = bus_oe ? bus_val : 'z;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a 16-byte instance and a 256-byte
// instance, each with a MAR + RAM model hanging off its bus.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst16 = 1'b0;
  logic       rst256 = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic       in_ready16, mai16, mi16, cpu_hold16, busy16, done16, aborted16;
  logic [7:0] checksum16;
  wire  [7:0] bus16;
  logic       in_ready256, mai256, mi256, cpu_hold256, busy256, done256, aborted256;
  logic [7:0] checksum256;
  wire  [7:0] bus256;

  logic [7:0] mar16, mar256, last_wr256;
  logic [7:0] ram16 [256];
  logic [7:0] ram256 [256];
  int         wr_cnt256 = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_loader #(.MEM_DEPTH(16), .DATA_WIDTH(8)) dut16 (
    .clk(clk), .rst(rst16), .start(start), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready16), .bus(bus16), .mai(mai16), .mi(mi16),
    .cpu_hold(cpu_hold16), .busy(busy16), .done(done16), .aborted(aborted16),
    .checksum(checksum16)
  );

  program_loader #(.MEM_DEPTH(256), .DATA_WIDTH(8)) dut256 (
    .clk(clk), .rst(rst256), .start(start), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready256), .bus(bus256), .mai(mai256), .mi(mi256),
    .cpu_hold(cpu_hold256), .busy(busy256), .done(done256), .aborted(aborted256),
    .checksum(checksum256)
  );

  // MAR and RAM models: both latch from the bus on the edge ending the cycle.
  always @(posedge clk) begin
    if (mai16) mar16 <= bus16;
    if (mi16) ram16[mar16] <= bus16;
    if (mai256) mar256 <= bus256;
    if (mi256) begin
      ram256[mar256] <= bus256;
      last_wr256     <= mar256;
      wr_cnt256      <= wr_cnt256 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int mode, input int idx);
    case (mode)
      0:       return 8'(idx);
      1:       return 8'(idx * 3);
      2:       return 8'hFF;
      default: return 8'(idx + 8'h40);
    endcase
  endfunction

  function automatic logic rdy_f(input bit big);
    return big ? in_ready256 : in_ready16;
  endfunction
  function automatic logic mai_f(input bit big);
    return big ? mai256 : mai16;
  endfunction
  function automatic logic mi_f(input bit big);
    return big ? mi256 : mi16;
  endfunction
  function automatic logic done_f(input bit big);
    return big ? done256 : done16;
  endfunction
  function automatic logic hold_f(input bit big);
    return big ? cpu_hold256 : cpu_hold16;
  endfunction

  // Pulse start, then feed bytes until cpu_hold falls. Cycle 1 is the first
  // in_ready cycle; done_cyc is the cycle done was seen, fall_cyc the first
  // cycle with cpu_hold low.
  task automatic run_load(input bit big, input int mode, input int stall, input bit hold_start,
                          output int done_cyc, output int done_cnt, output int fall_cyc,
                          output int bad, output int accepted);
    int  c, idx, wcnt;
    bit  acc, stalled;
    done_cyc = 0; done_cnt = 0; fall_cyc = 0; bad = 0; idx = 0; wcnt = 0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    c = 1;
    while (c < 4000) begin
      acc = 1'b0; stalled = 1'b0;
      if (rdy_f(big)) begin
        in_valid = (wcnt >= stall);
        in_data  = byte_of(mode, idx);
        acc      = in_valid;
        stalled  = !in_valid;
      end else begin
        in_valid = (stall == 0);
        wcnt     = 0;
      end
      if (mai_f(big) && mi_f(big)) bad++;
      if (done_f(big)) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
      if (acc) begin idx++; wcnt = 0; end
      if (stalled) begin
        wcnt++;
        if (!rdy_f(big) || mai_f(big) || mi_f(big)) bad++;
      end
      if (!hold_f(big)) begin fall_cyc = c; break; end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    accepted = idx;
  endtask

  initial begin
    int dc, dn, fc, bad, acc, miss, idx;
    bit found;

    // Reset state
    #3;
    chk("rst_in_ready", in_ready16, 1'b0);
    chk("rst_mai_mi", {mai16, mi16}, 2'b00);
    chk("rst_hold_busy", {cpu_hold16, busy16}, 2'b00);
    chk("rst_done_aborted", {done16, aborted16}, 2'b00);
    chk("rst_checksum", checksum16, 8'h00);
    #4 rst16 = 1'b1;

    // 1: back-to-back load of 0x00..0x0F
    run_load(1'b0, 0, 0, 1'b0, dc, dn, fc, bad, acc);
    chk("t1_done_cycle", dc, 49);
    chk("t1_done_count", dn, 1);
    chk("t1_hold_fall", fc, 50);
    chk("t1_accepted", acc, 16);
    chk("t1_checksum", checksum16, 8'h78);
    chk("t1_no_overlap", bad, 0);
    miss = 0;
    for (int i = 0; i < 16; i++) if (ram16[i] !== 8'(i)) miss++;
    chk("t1_ram", miss, 0);

    // 2: five idle cycles before every byte, data i*3
    run_load(1'b0, 1, 5, 1'b0, dc, dn, fc, bad, acc);
    chk("t2_done_cycle", dc, 129);
    chk("t2_stall_behaviour", bad, 0);
    chk("t2_checksum", checksum16, 8'h68);
    miss = 0;
    for (int i = 0; i < 16; i++) if (ram16[i] !== 8'(i * 3)) miss++;
    chk("t2_ram", miss, 0);

    // 3: abort during the WRITE of byte 3, data i+0x40
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      in_data = byte_of(3, idx);
      if (mi16 && mar16 == 8'd3) begin found = 1'b1; break; end
      acc = int'(in_ready16);
      @(posedge clk); #1;
      if (acc != 0) idx++;
    end
    chk("t3_reached_write3", found, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("t3_ram3_written", ram16[3], 8'h43);
    chk("t3_ram4_untouched", ram16[4], 8'h0C);
    chk("t3_idle", {busy16, cpu_hold16, done16}, 3'b000);
    chk("t3_aborted", aborted16, 1'b1);
    chk("t3_checksum", checksum16, 8'h06);
    @(posedge clk); #1;
    chk("t3_no_done", done16, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t3_start_clears", {aborted16, busy16}, 2'b01);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t3_abort_in_wait", {aborted16, busy16}, 2'b10);

    // 4: start held and in_valid high across ADDR/WRITE for a whole load
    run_load(1'b0, 0, 0, 1'b1, dc, dn, fc, bad, acc);
    chk("t4_done_cycle", dc, 49);
    chk("t4_done_count", dn, 1);
    chk("t4_accepted", acc, 16);
    chk("t4_checksum", checksum16, 8'h78);
    chk("t4_aborted_cleared", aborted16, 1'b0);
    miss = 0;
    for (int i = 0; i < 16; i++) if (ram16[i] !== 8'(i)) miss++;
    chk("t4_ram", miss, 0);

    // 5: async reset in the middle of an ADDR cycle
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mai16) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("t5_in_addr", found, 1'b1);
    #2 rst16 = 1'b0;
    #1;
    chk("t5_async_ctl", {mai16, mi16, in_ready16, done16}, 4'b0000);
    chk("t5_async_hold", {cpu_hold16, busy16, aborted16}, 3'b000);
    chk("t5_async_checksum", checksum16, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    rst16 = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_after", {busy16, in_ready16, mai16}, 3'b000);

    // 6: 256-byte image of 0xFF on the wide instance
    rst16 = 1'b0;
    @(negedge clk);
    rst256 = 1'b1;
    run_load(1'b1, 2, 0, 1'b0, dc, dn, fc, bad, acc);
    chk("t6_done_cycle", dc, 769);
    chk("t6_done_count", dn, 1);
    chk("t6_checksum", checksum256, 8'h00);
    chk("t6_last_addr", last_wr256, 8'hFF);
    chk("t6_write_count", wr_cnt256, 256);
    chk("t6_ram_ends", {ram256[0], ram256[255]}, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
